// File: rtl/fft_pkg.sv
// ============================================================
// fft_pkg - shared sizes, FSM encodings and point decoding for the FFT frame source
// Rev 1.0
// ============================================================
`default_nettype none

package fft_pkg;

  localparam int POINT_MAX = 1024;
  localparam int ADDR_W    = 10;
  localparam int DWIDTH    = 32;
  localparam int POINT_W   = 11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  // A legal one-hot point already equals the frame length; anything else decodes to 0.
  function automatic logic [POINT_W-1:0] point_to_len(input logic [POINT_W-1:0] point);
    int ones;
    ones = 0;
    for (int k = 1; k < POINT_W; k++) begin
      ones = ones + int'(point[k]);
    end
    return (ones == 1 && !point[0]) ? point : '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_sample_ram.sv
// ============================================================
// fft_sample_ram - one write port, one synchronous read port sample store
// Rev 1.0
// ============================================================
`default_nettype none

module fft_sample_ram #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DWIDTH-1:0] o_rdata
);

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [DWIDTH-1:0] r_rdata;

  // Write-first on an address collision so a same-cycle write is seen by the read.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/fft_frame_source.sv
// ============================================================
// fft_frame_source - replays a stored sample frame as AXI-Stream, N times or until stopped
// Rev 1.0
// ============================================================
`default_nettype none

module fft_frame_source #(
  parameter int DWIDTH    = fft_pkg::DWIDTH,
  parameter int MAX_POINT = fft_pkg::POINT_MAX,
  parameter int ADDR_W    = fft_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DWIDTH-1:0] i_wr_data,
  input  logic [10:0]       i_point,
  input  logic [7:0]        i_frames,
  input  logic              i_start,
  input  logic              i_stop,
  output logic [DWIDTH-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  import fft_pkg::*;

  localparam int LEN_W = ADDR_W + 1;

  logic [1:0]        r_state;
  logic [LEN_W-1:0]  r_len;
  logic [7:0]        r_frames;
  logic [7:0]        r_frame_cnt;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_stop;
  logic              r_err;
  logic              r_inflight;
  logic              r_inflight_last;
  logic [DWIDTH-1:0] r_fifo_data [2];
  logic [1:0]        r_fifo_last;
  logic              r_rptr;
  logic              r_wptr;
  logic [1:0]        r_cnt;

  logic [LEN_W-1:0]  w_start_len;
  logic              w_start_ok;
  logic              w_start_bad;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_credit;
  logic              w_rd_last;
  logic              w_final;
  logic              w_stream_issue;
  logic              w_issue;
  logic              w_issue_last;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DWIDTH-1:0] w_ram_rdata;
  logic              w_ram_we;
  logic              w_done;

  assign w_start_len = LEN_W'(point_to_len(i_point));
  assign w_start_ok  = (r_state == ST_IDLE) && i_start && (w_start_len != '0);
  assign w_start_bad = (r_state == ST_IDLE) && i_start && (w_start_len == '0);

  assign w_valid = (r_cnt != 2'd0);
  assign w_pop   = w_valid && m_axis_tready;
  assign w_push  = r_inflight;

  // Credit counts the slot freed by this cycle's pop so a steady tready keeps 1 beat/cycle.
  assign w_credit = ({1'b0, r_cnt} - {2'b00, w_pop} + {2'b00, r_inflight}) < 3'd2;

  assign w_rd_last = ({1'b0, r_rd_addr} == (r_len - LEN_W'(1)));
  assign w_final   = ((r_frames != 8'd0) && (r_frame_cnt == (r_frames - 8'd1))) || r_stop || i_stop;

  // Address 0 is read in the start cycle itself so the first beat appears two cycles later.
  assign w_stream_issue = (r_state == ST_STREAM) && w_credit;
  assign w_issue        = w_start_ok || w_stream_issue;
  assign w_issue_last   = w_stream_issue && w_rd_last;
  assign w_ram_addr     = w_start_ok ? '0 : r_rd_addr;
  assign w_ram_we       = i_wr_en && (r_state == ST_IDLE);

  assign w_done = (r_state == ST_DRAIN) && w_pop && m_axis_tlast;

  fft_sample_ram #(
    .DWIDTH (DWIDTH),
    .DEPTH  (MAX_POINT),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (i_wr_addr),
    .i_wdata (i_wr_data),
    .i_re    (w_issue),
    .i_raddr (w_ram_addr),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_frames    <= 8'd0;
      r_frame_cnt <= 8'd0;
      r_rd_addr   <= '0;
      r_stop      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_start_bad || (i_wr_en && (r_state != ST_IDLE));
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_state     <= ST_STREAM;
            r_len       <= w_start_len;
            r_frames    <= i_frames;
            r_frame_cnt <= 8'd0;
            r_rd_addr   <= ADDR_W'(1);
            r_stop      <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (i_stop) begin
            r_stop <= 1'b1;
          end
          if (w_stream_issue) begin
            if (w_rd_last) begin
              r_rd_addr <= '0;
              if (w_final) begin
                r_state <= ST_DRAIN;
              end else begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
              end
            end else begin
              r_rd_addr <= r_rd_addr + ADDR_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (w_done) begin
            r_state <= ST_IDLE;
            r_stop  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Two-entry skid FIFO: the read credit guarantees a push never meets a full FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_fifo_last     <= 2'b00;
      r_rptr          <= 1'b0;
      r_wptr          <= 1'b0;
      r_cnt           <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
      end
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue_last;
      if (w_push) begin
        r_fifo_data[r_wptr] <= w_ram_rdata;
        r_fifo_last[r_wptr] <= r_inflight_last;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign m_axis_tdata  = r_fifo_data[r_rptr];
  assign m_axis_tvalid = w_valid;
  assign m_axis_tlast  = w_valid && r_fifo_last[r_rptr];
  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = w_done;
  assign o_err         = r_err;

endmodule

`default_nettype wire
